// File: rtl/common.sv
// Shared definitions for the main memory model.
// Holds the timing/geometry parameters, the physical address and cache line
// types, the controller state encoding and two address helper functions.
package common;

   localparam int MEM_LATENCY      = 4;
   localparam int MEM_REQ_DEPTH    = 4;
   localparam int MEM_LINES        = 64;
   localparam int LINE_OFFSET_BITS = 4;
   localparam int PPTR_W           = 32;
   localparam int LINE_W           = 8 << LINE_OFFSET_BITS;
   localparam int LINE_IDX_W       = $clog2(MEM_LINES);

   typedef logic [PPTR_W-1:0]     pptr_t;
   typedef logic [LINE_W-1:0]     cacheline_t;
   typedef logic [LINE_IDX_W-1:0] line_idx_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESPOND = 2'd2
   } mem_state_e;

   // Clear the byte-offset bits, keeping the full line address.
   function automatic pptr_t line_align(input pptr_t addr);
      pptr_t res;
      res = addr;
      res[LINE_OFFSET_BITS-1:0] = '0;
      return res;
   endfunction

   // Array index of an address; MEM_LINES is a power of two, so slicing
   // the low line-number bits is the modulo wrap.
   function automatic line_idx_t line_index(input pptr_t addr);
      return addr[LINE_OFFSET_BITS +: LINE_IDX_W];
   endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue for main_memory.
// Ports: clk/rst (async active-low), push/din write the tail, pop drops the
// head shown on dout, full/empty status, cmp_addr is compared against every
// valid entry and cmp_hit flags each matching entry (duplicate detection).
// A push while full is legal only together with a pop at the same edge.
module mem_req_fifo
   import common::*;
#(
   parameter int DEPTH = MEM_REQ_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  pptr_t            din,
   output pptr_t            dout,
   output logic             full,
   output logic             empty,
   input  pptr_t            cmp_addr,
   output logic [DEPTH-1:0] cmp_hit
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   pptr_t            slot_q [DEPTH];
   pptr_t            slot_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   assign dout  = slot_q[rd_ptr_q];
   assign full  = &valid_q;
   assign empty = ~|valid_q;

   // Next-state: pop clears the head slot first so that a simultaneous push
   // into a full queue (same slot) re-marks it valid.
   always_comb begin
      slot_d   = slot_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push) begin
         valid_d[wr_ptr_q] = 1'b1;
         slot_d[wr_ptr_q]  = din;
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
   end

   // Per-entry address compare against the incoming request.
   always_comb begin
      cmp_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cmp_hit[i] = valid_q[i] && (slot_q[i] == cmp_addr);
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         slot_q   <= slot_d;
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/main_memory.sv
// Fixed-latency line-granular main memory model.
// Ports: clk/rst (async active-low); mem_req_ren/mem_req_addr read request
// from fetch; mem_rec_en/mem_rec_addr/mem_rec_cacheline registered response;
// mem_wr_en/mem_wr_addr/mem_wr_cacheline full-line write; busy activity
// status; err_overflow sticky dropped-request flag.
// Requests are de-duplicated, queued, and served one at a time taking
// MEM_LATENCY+1 cycles each. The array itself is never reset.
module main_memory
   import common::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_req_ren,
   input  pptr_t      mem_req_addr,
   output logic       mem_rec_en,
   output pptr_t      mem_rec_addr,
   output cacheline_t mem_rec_cacheline,
   input  logic       mem_wr_en,
   input  pptr_t      mem_wr_addr,
   input  cacheline_t mem_wr_cacheline,
   output logic       busy,
   output logic       err_overflow
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   pptr_t            cur_addr_q, cur_addr_d;
   logic             rec_en_q, rec_en_d;
   pptr_t            rec_addr_q, rec_addr_d;
   cacheline_t       rec_line_q, rec_line_d;
   logic             err_q, err_d;
   cacheline_t       mem_q [MEM_LINES];

   logic                     fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
   pptr_t                    fifo_head_s;
   logic [MEM_REQ_DEPTH-1:0] fifo_hit_s;
   pptr_t                    req_line_s;
   logic                     dup_s;
   line_idx_t                cap_idx_s;
   cacheline_t               cap_line_s;
   logic                     addr_unused_s;

   // Offset bits and wrapped-away high bits do not select array storage.
   assign addr_unused_s = ^{mem_req_addr, mem_wr_addr};

   assign req_line_s = line_align(mem_req_addr);

   mem_req_fifo #(.DEPTH(MEM_REQ_DEPTH)) u_req_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push_s),
      .pop      (fifo_pop_s),
      .din      (req_line_s),
      .dout     (fifo_head_s),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s),
      .cmp_addr (req_line_s),
      .cmp_hit  (fifo_hit_s)
   );

   // Capture data, forwarding a same-edge write to the line being returned.
   always_comb begin
      cap_idx_s = line_index(cur_addr_q);
      if (mem_wr_en && (line_index(mem_wr_addr) == cap_idx_s)) begin
         cap_line_s = mem_wr_cacheline;
      end else begin
         cap_line_s = mem_q[cap_idx_s];
      end
   end

   // Controller next-state, request admission and response capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_addr_d = cur_addr_q;
      rec_en_d   = 1'b0;
      rec_addr_d = rec_addr_q;
      rec_line_d = rec_line_q;
      err_d      = err_q;
      fifo_pop_s = 1'b0;

      case (state_q)
         IDLE, RESPOND: begin
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               cur_addr_d = fifo_head_s;
               cnt_d      = CNT_LOAD;
               state_d    = BUSY;
            end else begin
               state_d    = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d    = RESPOND;
               rec_en_d   = 1'b1;
               rec_addr_d = cur_addr_q;
               rec_line_d = cap_line_s;
            end else begin
               cnt_d      = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // cur_addr_q is only meaningful while a line is in flight.
      dup_s = (|fifo_hit_s) ||
              ((state_q != IDLE) && (cur_addr_q == req_line_s));
      fifo_push_s = mem_req_ren && !dup_s && (!fifo_full_s || fifo_pop_s);
      if (mem_req_ren && !dup_s && fifo_full_s && !fifo_pop_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Controller and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_addr_q <= '0;
         rec_en_q   <= 1'b0;
         rec_addr_q <= '0;
         rec_line_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_addr_q <= cur_addr_d;
         rec_en_q   <= rec_en_d;
         rec_addr_q <= rec_addr_d;
         rec_line_q <= rec_line_d;
         err_q      <= err_d;
      end
   end

   // Storage array: contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr_en) begin
         mem_q[line_index(mem_wr_addr)] <= mem_wr_cacheline;
      end
   end

   assign mem_rec_en        = rec_en_q;
   assign mem_rec_addr      = rec_addr_q;
   assign mem_rec_cacheline = rec_line_q;
   assign err_overflow      = err_q;
   assign busy              = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;
   import common::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_req_ren;
   pptr_t      mem_req_addr;
   logic       mem_rec_en;
   pptr_t      mem_rec_addr;
   cacheline_t mem_rec_cacheline;
   logic       mem_wr_en;
   pptr_t      mem_wr_addr;
   cacheline_t mem_wr_cacheline;
   logic       busy;
   logic       err_overflow;

   main_memory dut (
      .clk               (clk),
      .rst               (rst),
      .mem_req_ren       (mem_req_ren),
      .mem_req_addr      (mem_req_addr),
      .mem_rec_en        (mem_rec_en),
      .mem_rec_addr      (mem_rec_addr),
      .mem_rec_cacheline (mem_rec_cacheline),
      .mem_wr_en         (mem_wr_en),
      .mem_wr_addr       (mem_wr_addr),
      .mem_wr_cacheline  (mem_wr_cacheline),
      .busy              (busy),
      .err_overflow      (err_overflow)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge number k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   int         log_t[$];
   pptr_t      log_addr[$];
   cacheline_t log_data[$];

   // Response monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_rec_en === 1'b1) begin
         log_t.push_back(cyc);
         log_addr.push_back(mem_rec_addr);
         log_data.push_back(mem_rec_cacheline);
      end
   end

   localparam cacheline_t PAT_A = {4{32'hA5A5_0010}};
   localparam cacheline_t PAT_B = {4{32'hBBBB_0007}};
   localparam cacheline_t PAT_C = {4{32'hCCCC_0007}};
   localparam cacheline_t PAT_D = {4{32'hDDDD_0020}};

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic pptr_t la(input int n);
      return pptr_t'(n) << LINE_OFFSET_BITS;
   endfunction

   function automatic cacheline_t pat(input int n);
      return {4{32'h1000_0000 + 32'(n)}};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_line(input int idx, input cacheline_t data);
      mem_wr_en        = 1'b1;
      mem_wr_addr      = la(idx);
      mem_wr_cacheline = data;
      tick(1);
      mem_wr_en        = 1'b0;
   endtask

   // Issue one request; t is the edge at which it is sampled.
   task automatic req(input pptr_t addr, output int t);
      t            = cyc + 1;
      mem_req_ren  = 1'b1;
      mem_req_addr = addr;
      tick(1);
      mem_req_ren  = 1'b0;
   endtask

   task automatic clear_log();
      log_t.delete();
      log_addr.delete();
      log_data.delete();
   endtask

   int t0, t1, tx;

   initial begin
      rst              = 1'b0;
      mem_req_ren      = 1'b0;
      mem_req_addr     = '0;
      mem_wr_en        = 1'b0;
      mem_wr_addr      = '0;
      mem_wr_cacheline = '0;
      tick(3);
      chk("rst_rec_en", mem_rec_en, 1'b0);
      chk("rst_rec_addr", mem_rec_addr, '0);
      chk("rst_rec_line", mem_rec_cacheline, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_overflow, 1'b0);
      rst = 1'b1;
      tick(2);

      // Single request latency and data.
      wr_line(16, PAT_A);
      for (int i = 1; i <= 3; i++) wr_line(i, pat(i));
      clear_log();
      req(la(16), t0);
      tick(10);
      chk("t1_count", log_t.size(), 1);
      chk("t1_time", log_t[0], t0 + MEM_LATENCY + 1);
      chk("t1_addr", log_addr[0], la(16));
      chk("t1_data", log_data[0], PAT_A);
      chk("t1_hold_en", mem_rec_en, 1'b0);
      chk("t1_hold_addr", mem_rec_addr, la(16));
      chk("t1_hold_data", mem_rec_cacheline, PAT_A);
      chk("t1_busy", busy, 1'b0);

      // Three back-to-back requests, offsets ignored.
      clear_log();
      req(la(1) + 32'd3, t0);
      req(la(2), tx);
      req(la(3) + 32'd15, tx);
      chk("t2_busy_hi", busy, 1'b1);
      tick(20);
      chk("t2_count", log_t.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_addr%0d", i), log_addr[i], la(i + 1));
         chk($sformatf("t2_data%0d", i), log_data[i], pat(i + 1));
         chk($sformatf("t2_time%0d", i), log_t[i], t0 + (i + 1) * (MEM_LATENCY + 1));
      end
      chk("t2_busy_lo", busy, 1'b0);

      // Duplicate requests collapse into one.
      clear_log();
      req(la(5), t0);
      req(la(5) + 32'd1, tx);
      req(la(5) + 32'd2, tx);
      tick(12);
      chk("t3_count", log_t.size(), 1);
      chk("t3_addr", log_addr[0], la(5));
      chk("t3_err", err_overflow, 1'b0);

      // Overflow: six distinct requests, sixth dropped.
      clear_log();
      for (int i = 0; i < 6; i++) req(la(8 + i), tx);
      tick(35);
      chk("t4_count", log_t.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_addr%0d", i), log_addr[i], la(8 + i));
      end
      chk("t4_err", err_overflow, 1'b1);
      chk("t4_busy", busy, 1'b0);

      // Write forwarded into a same-edge response capture.
      wr_line(7, PAT_C);
      clear_log();
      req(la(7), t0);
      tick(MEM_LATENCY);
      mem_wr_en        = 1'b1;
      mem_wr_addr      = la(7);
      mem_wr_cacheline = PAT_B;
      tick(1);
      mem_wr_en        = 1'b0;
      tick(6);
      chk("t5_count", log_t.size(), 1);
      chk("t5_time", log_t[0], t0 + MEM_LATENCY + 1);
      chk("t5_fwd_data", log_data[0], PAT_B);
      clear_log();
      req(la(MEM_LINES + 7), t0);
      tick(8);
      chk("t5_wrap_addr", log_addr[0], la(MEM_LINES + 7));
      chk("t5_wrap_data", log_data[0], PAT_B);
      chk("t5_err_sticky", err_overflow, 1'b1);

      // Reset while busy.
      wr_line(20, PAT_D);
      clear_log();
      req(la(20), t0);
      tick(2);
      rst = 1'b0;
      #1;
      chk("t6_rec_en", mem_rec_en, 1'b0);
      chk("t6_rec_addr", mem_rec_addr, '0);
      chk("t6_rec_line", mem_rec_cacheline, '0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_err", err_overflow, 1'b0);
      tick(2);
      rst = 1'b1;
      tick(10);
      chk("t6_no_resp", log_t.size(), 0);
      req(la(20), t0);
      tick(8);
      chk("t6_keep20", log_data[0], PAT_D);
      req(la(16), t0);
      tick(8);
      chk("t6_keep16", log_data[1], PAT_A);
      chk("t6_count", log_t.size(), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
